// File: rtl/la_capture_ctrl.sv
// Capture sequencer for the logic-analyzer sample memory: arm, pre-trigger fill,
// trigger wait and post-trigger recording, driving a registered sample-BRAM write port.
module la_capture_ctrl #(
    parameter int SAMPLE_DEPTH = 1024,
    parameter int PROBE_W      = 29,
    localparam int ADDR_W      = $clog2(SAMPLE_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm_req,
    input  logic               stop_req,
    input  logic [ADDR_W-1:0]  trig_pos,
    input  logic               trig_in,
    input  logic [PROBE_W-1:0] probes_in,
    output logic               mem_wr_en,
    output logic [ADDR_W-1:0]  mem_wr_addr,
    output logic [PROBE_W-1:0] mem_wr_data,
    output logic [1:0]         state_o,
    output logic [ADDR_W-1:0]  base_addr_o,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_ARMED   = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t               state_r;
    logic [ADDR_W-1:0]    wr_ptr_r;
    logic [ADDR_W-1:0]    remaining_r;
    logic [ADDR_W-1:0]    trig_pos_q_r;
    logic [ADDR_W-1:0]    base_r;
    logic                 wr_en_r;
    logic [ADDR_W-1:0]    wr_addr_r;
    logic [PROBE_W-1:0]   wr_data_r;
    logic [ADDR_W-1:0]    base_addr_r;
    logic                 done_r;

    logic                 sample_s;
    logic                 fill_last_s;
    logic                 cap_last_s;
    logic [ADDR_W-1:0]    trig_base_s;
    logic [ADDR_W-1:0]    tail_s;

    // Decode which cycles take a sample and which sample closes the current phase
    always_comb begin
        sample_s    = 1'b0;
        fill_last_s = 1'b0;
        cap_last_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                sample_s = 1'b0;
            end
            ST_FILL: begin
                sample_s    = ~stop_req;
                fill_last_s = (wr_ptr_r == (trig_pos_q_r - ADDR_W'(1)));
            end
            ST_ARMED: begin
                sample_s = ~stop_req;
            end
            ST_CAPTURE: begin
                sample_s   = ~stop_req;
                cap_last_s = (remaining_r == ADDR_W'(1));
            end
            default: begin
                sample_s = 1'b0;
            end
        endcase
        // Modular arithmetic in ADDR_W bits gives the circular wrap for free
        trig_base_s = wr_ptr_r - trig_pos_q_r;
        tail_s      = {ADDR_W{1'b1}} - trig_pos_q_r;
    end

    // Capture sequencer with registered write beat and status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            wr_ptr_r     <= {ADDR_W{1'b0}};
            remaining_r  <= {ADDR_W{1'b0}};
            trig_pos_q_r <= {ADDR_W{1'b0}};
            base_r       <= {ADDR_W{1'b0}};
            wr_en_r      <= 1'b0;
            wr_addr_r    <= {ADDR_W{1'b0}};
            wr_data_r    <= {PROBE_W{1'b0}};
            base_addr_r  <= {ADDR_W{1'b0}};
            done_r       <= 1'b0;
        end else begin
            wr_en_r <= sample_s;
            if (sample_s) begin
                wr_addr_r <= wr_ptr_r;
                wr_data_r <= probes_in;
                wr_ptr_r  <= wr_ptr_r + ADDR_W'(1);
            end

            case (state_r)
                ST_IDLE: begin
                    // A simultaneous stop cancels the arm request
                    if (arm_req && !stop_req) begin
                        trig_pos_q_r <= trig_pos;
                        wr_ptr_r     <= {ADDR_W{1'b0}};
                        done_r       <= 1'b0;
                        if (trig_pos == {ADDR_W{1'b0}}) begin
                            state_r <= ST_ARMED;
                        end else begin
                            state_r <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (stop_req) begin
                        state_r <= ST_IDLE;
                    end else if (fill_last_s) begin
                        state_r <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (stop_req) begin
                        state_r <= ST_IDLE;
                    end else if (trig_in) begin
                        base_r      <= trig_base_s;
                        remaining_r <= tail_s;
                        if (tail_s == {ADDR_W{1'b0}}) begin
                            state_r     <= ST_IDLE;
                            done_r      <= 1'b1;
                            base_addr_r <= trig_base_s;
                        end else begin
                            state_r <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (stop_req) begin
                        state_r <= ST_IDLE;
                    end else if (cap_last_s) begin
                        remaining_r <= {ADDR_W{1'b0}};
                        state_r     <= ST_IDLE;
                        done_r      <= 1'b1;
                        base_addr_r <= base_r;
                    end else begin
                        remaining_r <= remaining_r - ADDR_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_wr_en   = wr_en_r;
    assign mem_wr_addr = wr_addr_r;
    assign mem_wr_data = wr_data_r;
    assign state_o     = state_r;
    assign base_addr_o = base_addr_r;
    assign done        = done_r;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Directed bench for la_capture_ctrl at SAMPLE_DEPTH=16 with a cycle counter on the probe bus.
module tb_la_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm_req = 1'b0;
    logic        stop_req = 1'b0;
    logic [3:0]  trig_pos = 4'd0;
    logic        trig_in = 1'b0;
    logic [28:0] probes_in = 29'd0;
    logic        mem_wr_en;
    logic [3:0]  mem_wr_addr;
    logic [28:0] mem_wr_data;
    logic [1:0]  state_o;
    logic [3:0]  base_addr_o;
    logic        done;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          c = 0;
    int          trig_a = -1;
    int          trig_b = -1;
    int          trig_c = -1;
    int          stop_at = -1;
    logic        trig_hold = 1'b0;
    logic        saw_capture = 1'b0;
    logic [28:0] shadow [16];
    int          wr_count = 0;

    la_capture_ctrl #(.SAMPLE_DEPTH(16), .PROBE_W(29)) dut (
        .clk(clk), .rst(rst), .arm_req(arm_req), .stop_req(stop_req),
        .trig_pos(trig_pos), .trig_in(trig_in), .probes_in(probes_in),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .state_o(state_o), .base_addr_o(base_addr_o), .done(done)
    );

    always #5 clk = ~clk;

    task automatic drive();
        probes_in = c[28:0];
        trig_in   = trig_hold | (c == trig_a) | (c == trig_b) | (c == trig_c);
        stop_req  = (c == stop_at);
    endtask

    // One clock: sample outputs 1 time unit after the edge, record the visible beat, advance c
    task automatic cyc();
        @(posedge clk);
        #1;
        if (mem_wr_en === 1'b1) begin
            shadow[mem_wr_addr] = mem_wr_data;
            wr_count++;
        end
        if (state_o === 2'd3) saw_capture = 1'b1;
        c++;
        drive();
    endtask

    task automatic start_capture(input logic [3:0] tp);
        for (int i = 0; i < 16; i++) shadow[i] = 29'd0;
        wr_count    = 0;
        saw_capture = 1'b0;
        c           = 0;
        trig_pos    = tp;
        arm_req     = 1'b1;
        drive();
    endtask

    task automatic wait_done(input int max);
        int n;
        n = 0;
        while (done !== 1'b1 && n < max) begin
            cyc();
            n++;
        end
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("FAIL wait_done timeout: done=%b required 1 after %0d cycles", done, max);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if ({mem_wr_en, mem_wr_addr, mem_wr_data, state_o, base_addr_o, done} !== 42'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: en=%b addr=%0d data=%0d state=%0d base=%0d done=%b required all 0",
                     mem_wr_en, mem_wr_addr, mem_wr_data, state_o, base_addr_o, done);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        cyc();
        tests_run++;
        if (state_o !== 2'd0 || done !== 1'b0 || mem_wr_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: state=%0d done=%b en=%b required 0 0 0", state_o, done, mem_wr_en);
        end
    endtask

    task automatic test_pretrigger();
        int bad;
        trig_a = 20;
        start_capture(4'd4);
        cyc();
        arm_req  = 1'b0;
        trig_pos = 4'd9;
        tests_run++;
        if (state_o !== 2'd1 || mem_wr_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL pre_arm: state=%0d en=%b required 1 0", state_o, mem_wr_en);
        end
        wait_done(60);
        tests_run++;
        if (c != 32 || mem_wr_en !== 1'b1 || mem_wr_addr !== 4'd14 || mem_wr_data !== 29'd31) begin
            tests_failed++;
            $display("FAIL pre_final_beat: c=%0d en=%b addr=%0d data=%0d required 32 1 14 31",
                     c, mem_wr_en, mem_wr_addr, mem_wr_data);
        end
        tests_run++;
        if (base_addr_o !== 4'd15 || state_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL pre_status: base=%0d state=%0d required 15 0", base_addr_o, state_o);
        end
        bad = 0;
        for (int i = 0; i < 15; i++) if (shadow[i] !== 29'(17 + i)) bad++;
        tests_run++;
        if (bad != 0 || shadow[15] !== 29'd16 || wr_count != 31) begin
            tests_failed++;
            $display("FAIL pre_memory: bad=%0d mem15=%0d writes=%0d required 0 16 31", bad, shadow[15], wr_count);
        end
        trig_a = -1;
    endtask

    task automatic test_zero_pretrigger();
        int bad;
        trig_hold = 1'b1;
        start_capture(4'd0);
        cyc();
        arm_req = 1'b0;
        tests_run++;
        if (state_o !== 2'd2) begin
            tests_failed++;
            $display("FAIL zero_armed: state=%0d required 2", state_o);
        end
        wait_done(40);
        bad = 0;
        for (int i = 0; i < 16; i++) if (shadow[i] !== 29'(i + 1)) bad++;
        tests_run++;
        if (c != 17 || base_addr_o !== 4'd0 || bad != 0) begin
            tests_failed++;
            $display("FAIL zero_result: c=%0d base=%0d bad=%0d required 17 0 0", c, base_addr_o, bad);
        end
        trig_hold = 1'b0;
        drive();
    endtask

    task automatic test_full_pretrigger();
        trig_a = 3;
        trig_b = 10;
        trig_c = 40;
        start_capture(4'd15);
        cyc();
        arm_req = 1'b0;
        wait_done(80);
        tests_run++;
        if (c != 41 || mem_wr_addr !== 4'd7 || mem_wr_data !== 29'd40 || base_addr_o !== 4'd8) begin
            tests_failed++;
            $display("FAIL full_result: c=%0d addr=%0d data=%0d base=%0d required 41 7 40 8",
                     c, mem_wr_addr, mem_wr_data, base_addr_o);
        end
        tests_run++;
        if (saw_capture !== 1'b0 || state_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL full_no_capture: saw_capture=%b state=%0d required 0 0", saw_capture, state_o);
        end
        trig_a = -1; trig_b = -1; trig_c = -1;
    endtask

    task automatic test_stop_capture();
        trig_a  = 5;
        stop_at = 8;
        start_capture(4'd2);
        cyc();
        arm_req = 1'b0;
        while (c < 8) cyc();
        tests_run++;
        if (state_o !== 2'd3 || mem_wr_en !== 1'b1 || mem_wr_addr !== 4'd6) begin
            tests_failed++;
            $display("FAIL stop_inflight: state=%0d en=%b addr=%0d required 3 1 6", state_o, mem_wr_en, mem_wr_addr);
        end
        cyc();
        tests_run++;
        if (state_o !== 2'd0 || done !== 1'b0 || mem_wr_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL stop_idle: state=%0d done=%b en=%b required 0 0 0", state_o, done, mem_wr_en);
        end
        stop_at = -1;
        repeat (5) cyc();
        tests_run++;
        if (wr_count != 7 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL stop_writes: writes=%0d done=%b required 7 0", wr_count, done);
        end
        trig_a = 10;
        start_capture(4'd3);
        cyc();
        arm_req = 1'b0;
        wait_done(60);
        tests_run++;
        if (c != 23 || base_addr_o !== 4'd6 || mem_wr_addr !== 4'd5 || mem_wr_data !== 29'd22) begin
            tests_failed++;
            $display("FAIL rearm_result: c=%0d base=%0d addr=%0d data=%0d required 23 6 5 22",
                     c, base_addr_o, mem_wr_addr, mem_wr_data);
        end
        trig_a = -1;
    endtask

    task automatic test_arm_conflicts();
        stop_at = 0;
        start_capture(4'd5);
        cyc();
        arm_req = 1'b0;
        stop_at = -1;
        tests_run++;
        if (state_o !== 2'd0 || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL arm_stop_same: state=%0d done=%b required 0 1", state_o, done);
        end
        repeat (4) cyc();
        tests_run++;
        if (wr_count != 0) begin
            tests_failed++;
            $display("FAIL arm_stop_writes: writes=%0d required 0", wr_count);
        end
        trig_a = 6;
        start_capture(4'd2);
        cyc();
        arm_req = 1'b0;
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL arm_clears_done: done=%b required 0", done);
        end
        while (c < 5) cyc();
        arm_req  = 1'b1;
        trig_pos = 4'd0;
        cyc();
        arm_req = 1'b0;
        tests_run++;
        if (state_o !== 2'd2 || mem_wr_addr !== 4'd4 || mem_wr_data !== 29'd5) begin
            tests_failed++;
            $display("FAIL armed_rearm_ignored: state=%0d addr=%0d data=%0d required 2 4 5",
                     state_o, mem_wr_addr, mem_wr_data);
        end
        wait_done(40);
        tests_run++;
        if (c != 20 || base_addr_o !== 4'd3 || mem_wr_addr !== 4'd2) begin
            tests_failed++;
            $display("FAIL armed_rearm_result: c=%0d base=%0d addr=%0d required 20 3 2", c, base_addr_o, mem_wr_addr);
        end
        trig_a = -1;
    endtask

    task automatic test_async_reset();
        trig_a = 3;
        start_capture(4'd1);
        cyc();
        arm_req = 1'b0;
        while (c < 6) cyc();
        rst = 1'b0;
        #1;
        tests_run++;
        if ({mem_wr_en, mem_wr_addr, mem_wr_data, state_o, base_addr_o, done} !== 42'd0) begin
            tests_failed++;
            $display("FAIL async_reset: en=%b addr=%0d data=%0d state=%0d base=%0d done=%b required all 0",
                     mem_wr_en, mem_wr_addr, mem_wr_data, state_o, base_addr_o, done);
        end
        #2 rst = 1'b1;
        trig_a = -1;
        drive();
        repeat (2) cyc();
        tests_run++;
        if (state_o !== 2'd0 || done !== 1'b0 || mem_wr_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_release: state=%0d done=%b en=%b required 0 0 0", state_o, done, mem_wr_en);
        end
    endtask

    initial begin
        test_reset();
        test_pretrigger();
        test_zero_pretrigger();
        test_full_pretrigger();
        test_stop_capture();
        test_arm_conflicts();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
